// File: rtl/sram_arb_ctrl_pkg.sv
// Shared types and constants for the two-port SRAM controller.
// States, port identifiers and data widths.
package sram_arb_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO_P,
    WR_LO_R,
    WR_HI_P,
    WR_HI_R,
    RESP
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int DW  = 32;
  localparam int HW  = 16;
  localparam int BEW = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// On contention the port that did not win last time is granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       last_grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11)
      grant = last_grant ? 2'b01 : 2'b10;
  end

  // Reset to port 1 so port 0 wins the first contention
  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b1;
    else if (advance && (|req))
      last_grant <= grant[1];
  end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Async 16-bit SRAM sequencer shared by two 32-bit requesters.
// Each word access is split into two half-word SRAM cycles.
module sram_arb_ctrl
  import sram_arb_ctrl_pkg::*;
#(
  parameter int SRAM_AW = 18,
  parameter int BUS_AW  = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_req,
  input  logic               m0_write,
  input  logic [BUS_AW-1:0]  m0_addr,
  input  logic [DW-1:0]      m0_wdata,
  input  logic [BEW-1:0]     m0_byte_en,
  output logic               m0_ready,
  output logic [DW-1:0]      m0_rdata,
  input  logic               m1_req,
  input  logic               m1_write,
  input  logic [BUS_AW-1:0]  m1_addr,
  input  logic [DW-1:0]      m1_wdata,
  input  logic [BEW-1:0]     m1_byte_en,
  output logic               m1_ready,
  output logic [DW-1:0]      m1_rdata,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [1:0]         sram_be_n,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [HW-1:0]      sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [HW-1:0]      sram_dq_in
);

  localparam int WAW = SRAM_AW - 1;

  state_t state, nstate;

  logic [1:0]        req, grant;
  logic              advance, last_grant;
  logic              g_sel, g_write;
  logic [BUS_AW-1:0] g_addr;
  logic [DW-1:0]     g_wdata;
  logic [BEW-1:0]    g_be;

  logic [WAW-1:0] lat_addr, cur_addr;
  logic [DW-1:0]  lat_wdata, cur_wdata;
  logic [BEW-1:0] lat_be, cur_be;
  logic           lat_port, cur_port;
  logic [HW-1:0]  rd_lo;

  logic               hi, is_rd, is_wr, is_wp;
  logic               ce_d, oe_d, we_d, dqoe_d;
  logic [1:0]         be_d;
  logic [SRAM_AW-1:0] addr_d;
  logic [HW-1:0]      dq_d;
  logic               unused;

  assign req = {m1_req, m0_req};

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .advance   (advance),
    .grant     (grant),
    .last_grant(last_grant)
  );

  assign g_sel   = grant[1];
  assign g_write = g_sel ? m1_write   : m0_write;
  assign g_addr  = g_sel ? m1_addr    : m0_addr;
  assign g_wdata = g_sel ? m1_wdata   : m0_wdata;
  assign g_be    = g_sel ? m1_byte_en : m0_byte_en;

  assign unused = ^{g_addr[BUS_AW-1:SRAM_AW+1], g_addr[1:0]};

  always_comb begin
    nstate    = state;
    advance   = 1'b0;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    cur_be    = lat_be;
    cur_port  = lat_port;
    unique case (state)
      IDLE: begin
        if (|req) begin
          advance   = 1'b1;
          cur_addr  = g_addr[SRAM_AW:2];
          cur_wdata = g_wdata;
          cur_be    = g_be;
          cur_port  = g_sel;
          if (!g_write)
            nstate = RD_LO;
          else if (|g_be[1:0])
            nstate = WR_LO_P;
          else if (|g_be[3:2])
            nstate = WR_HI_P;
          else
            nstate = RESP;
        end
      end
      RD_LO:   nstate = RD_HI;
      RD_HI:   nstate = RESP;
      WR_LO_P: nstate = WR_LO_R;
      WR_LO_R: nstate = (|lat_be[3:2]) ? WR_HI_P : RESP;
      WR_HI_P: nstate = WR_HI_R;
      WR_HI_R: nstate = RESP;
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Pin values are computed for the upcoming state and registered
  always_comb begin
    hi = (nstate == RD_HI) || (nstate == WR_HI_P) ||
         (nstate == WR_HI_R);
    is_rd = (nstate == RD_LO) || (nstate == RD_HI);
    is_wp = (nstate == WR_LO_P) || (nstate == WR_HI_P);
    is_wr = is_wp || (nstate == WR_LO_R) ||
            (nstate == WR_HI_R);
    ce_d   = 1'b1;
    oe_d   = 1'b1;
    we_d   = 1'b1;
    be_d   = 2'b11;
    addr_d = sram_addr;
    dq_d   = sram_dq_out;
    dqoe_d = 1'b0;
    unique case (1'b1)
      is_rd: begin
        ce_d   = 1'b0;
        oe_d   = 1'b0;
        be_d   = 2'b00;
        addr_d = {cur_addr, hi};
      end
      is_wr: begin
        ce_d   = 1'b0;
        we_d   = !is_wp;
        dqoe_d = 1'b1;
        addr_d = {cur_addr, hi};
        dq_d   = hi ? cur_wdata[31:16] : cur_wdata[15:0];
        be_d   = hi ? ~cur_be[3:2] : ~cur_be[1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_be      <= '0;
      lat_port    <= M0;
      rd_lo       <= '0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_be_n   <= 2'b11;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      state <= nstate;
      if (advance) begin
        lat_addr  <= cur_addr;
        lat_wdata <= cur_wdata;
        lat_be    <= cur_be;
        lat_port  <= cur_port;
      end
      sram_ce_n   <= ce_d;
      sram_oe_n   <= oe_d;
      sram_we_n   <= we_d;
      sram_be_n   <= be_d;
      sram_addr   <= addr_d;
      sram_dq_out <= dq_d;
      sram_dq_oe  <= dqoe_d;
      m0_ready <= (nstate == RESP) && (cur_port == M0);
      m1_ready <= (nstate == RESP) && (cur_port == M1);
      if (state == RD_LO)
        rd_lo <= sram_dq_in;
      if (state == RD_HI) begin
        if (lat_port == M0)
          m0_rdata <= {sram_dq_in, rd_lo};
        else
          m1_rdata <= {sram_dq_in, rd_lo};
      end
    end
  end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Bench for sram_arb_ctrl: SRAM pin model plus word-level
// reference memory with byte-enable merge and latency rules.
module tb_sram_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req [2];
  logic        wr [2];
  logic [19:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  be [2];
  logic        rdy [2];
  logic [31:0] rdata [2];

  logic        ce_n, oe_n, we_n, dq_oe;
  logic [1:0]  be_n;
  logic [17:0] s_addr;
  logic [15:0] dq_out, dq_in;

  logic [15:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_a = '0;
  logic [15:0] pl_d = '0;

  logic [31:0] ref_mem [64];

  int total = 0;
  int bad = 0;
  int both_cnt = 0;
  int ce_cnt = 0;
  int rdy_cnt0 = 0;
  logic [17:0] rd_q [$];
  logic [35:0] wr_q [$];
  int grant_q [$];

  always #5 clk = ~clk;

  sram_arb_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .m0_req     (req[0]),
    .m0_write   (wr[0]),
    .m0_addr    (addr[0]),
    .m0_wdata   (wdata[0]),
    .m0_byte_en (be[0]),
    .m0_ready   (rdy[0]),
    .m0_rdata   (rdata[0]),
    .m1_req     (req[1]),
    .m1_write   (wr[1]),
    .m1_addr    (addr[1]),
    .m1_wdata   (wdata[1]),
    .m1_byte_en (be[1]),
    .m1_ready   (rdy[1]),
    .m1_rdata   (rdata[1]),
    .sram_ce_n  (ce_n),
    .sram_oe_n  (oe_n),
    .sram_we_n  (we_n),
    .sram_be_n  (be_n),
    .sram_addr  (s_addr),
    .sram_dq_out(dq_out),
    .sram_dq_oe (dq_oe),
    .sram_dq_in (dq_in)
  );

  assign dq_in = (!ce_n && !oe_n) ? mem[s_addr[9:0]] : 16'h0000;

  always @(posedge clk) begin
    if (pl_en)
      mem[pl_a] <= pl_d;
    else if (!ce_n && !we_n) begin
      if (!be_n[0]) mem[s_addr[9:0]][7:0]  <= dq_out[7:0];
      if (!be_n[1]) mem[s_addr[9:0]][15:8] <= dq_out[15:8];
    end
  end

  always @(negedge clk) begin
    if (rdy[0] && rdy[1]) both_cnt++;
    if (rdy[0]) begin rdy_cnt0++; grant_q.push_back(0); end
    if (rdy[1]) grant_q.push_back(1);
    if (!ce_n) ce_cnt++;
    if (!ce_n && !oe_n) rd_q.push_back(s_addr);
    if (!we_n) wr_q.push_back({s_addr, dq_out, be_n});
  end

  function automatic int exp_lat(logic w, logic [3:0] b);
    if (!w) return 3;
    if (b == 4'h0) return 1;
    if ((|b[1:0]) && (|b[3:2])) return 5;
    return 3;
  endfunction

  function automatic void ref_write(int wa, logic [31:0] d,
                                    logic [3:0] b);
    for (int k = 0; k < 4; k++)
      if (b[k]) ref_mem[wa][8*k +: 8] = d[8*k +: 8];
  endfunction

  task automatic set_word(int w, logic [31:0] v);
    ref_mem[w] = v;
    pl_en = 1'b1;
    pl_a = 10'(2*w);
    pl_d = v[15:0];
    @(negedge clk);
    pl_a = 10'(2*w + 1);
    pl_d = v[31:16];
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_access(input int p, input logic w,
                           input logic [19:0] a,
                           input logic [31:0] d,
                           input logic [3:0] b,
                           output int lat,
                           output logic [31:0] rd);
    req[p] = 1'b1; wr[p] = w; addr[p] = a;
    wdata[p] = d; be[p] = b;
    lat = -1; rd = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rdy[p]) begin lat = n; rd = rdata[p]; break; end
    end
    req[p] = 1'b0;
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL timeout port=%0d got no ready", p);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; wr[p] = 0; addr[p] = '0;
      wdata[p] = '0; be[p] = '0;
    end
    rst = 1'b1;
    @(negedge clk);
    for (int w = 0; w < 64; w++) set_word(w, $urandom);
    total++;
    if ({ce_n, oe_n, we_n, be_n, dq_oe} !== 6'b111110) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=111110",
               {ce_n, oe_n, we_n, be_n, dq_oe});
    end
    total++;
    if (s_addr !== 0 || dq_out !== 0) begin
      bad++;
      $display("FAIL reset_bus addr=%h dq=%h want 0", s_addr, dq_out);
    end
    total++;
    if (rdy[0] !== 0 || rdy[1] !== 0 || rdata[0] !== 0 ||
        rdata[1] !== 0) begin
      bad++;
      $display("FAIL reset_port rdy=%b%b rd0=%h rd1=%h want 0",
               rdy[1], rdy[0], rdata[0], rdata[1]);
    end
    rst = 1'b0;
  endtask

  task automatic test_read;
    int lat, s;
    logic [31:0] rd;
    set_word(4, 32'hDEADBEEF);
    s = rd_q.size();
    do_access(0, 0, 20'h00010, 32'h0, 4'h0, lat, rd);
    total++;
    if (lat !== 3) begin
      bad++; $display("FAIL read_lat got=%0d want=3", lat);
    end
    total++;
    if (rd !== 32'hDEADBEEF) begin
      bad++; $display("FAIL read_data got=%h want=deadbeef", rd);
    end
    total++;
    if (rd_q.size() - s != 2) begin
      bad++;
      $display("FAIL read_oe_cycles got=%0d want=2", rd_q.size() - s);
    end else if (rd_q[s] !== 18'h8 || rd_q[s+1] !== 18'h9) begin
      bad++;
      $display("FAIL read_addr got=%h,%h want=8,9", rd_q[s], rd_q[s+1]);
    end
  endtask

  task automatic test_write_full;
    int lat, s;
    logic [31:0] rd;
    s = wr_q.size();
    do_access(1, 1, 20'h00020, 32'h12345678, 4'hF, lat, rd);
    ref_write(8, 32'h12345678, 4'hF);
    total++;
    if (lat !== 5) begin
      bad++; $display("FAIL wfull_lat got=%0d want=5", lat);
    end
    total++;
    if (wr_q.size() - s != 2) begin
      bad++;
      $display("FAIL wfull_pulses got=%0d want=2", wr_q.size() - s);
    end else if (wr_q[s] !== {18'h10, 16'h5678, 2'b00} ||
                 wr_q[s+1] !== {18'h11, 16'h1234, 2'b00}) begin
      bad++;
      $display("FAIL wfull_pins got=%h,%h want=%h,%h", wr_q[s],
               wr_q[s+1], {18'h10, 16'h5678, 2'b00},
               {18'h11, 16'h1234, 2'b00});
    end
    do_access(1, 0, 20'h00020, 32'h0, 4'h0, lat, rd);
    total++;
    if (rd !== 32'h12345678) begin
      bad++; $display("FAIL wfull_readback got=%h want=12345678", rd);
    end
  endtask

  task automatic test_write_half;
    int lat, s, c;
    logic [31:0] rd;
    s = wr_q.size();
    do_access(1, 1, 20'h00020, 32'h00AB0000, 4'h4, lat, rd);
    ref_write(8, 32'h00AB0000, 4'h4);
    total++;
    if (lat !== 3) begin
      bad++; $display("FAIL whi_lat got=%0d want=3", lat);
    end
    total++;
    if (wr_q.size() - s != 1) begin
      bad++;
      $display("FAIL whi_pulses got=%0d want=1", wr_q.size() - s);
    end else if (wr_q[s] !== {18'h11, 16'h00AB, 2'b10}) begin
      bad++;
      $display("FAIL whi_pins got=%h want=%h", wr_q[s],
               {18'h11, 16'h00AB, 2'b10});
    end
    do_access(0, 0, 20'h00020, 32'h0, 4'h0, lat, rd);
    total++;
    if (rd !== ref_mem[8]) begin
      bad++; $display("FAIL whi_readback got=%h want=%h", rd, ref_mem[8]);
    end
    c = ce_cnt;
    do_access(0, 1, 20'h00024, $urandom, 4'h0, lat, rd);
    total++;
    if (lat !== 1 || ce_cnt != c) begin
      bad++;
      $display("FAIL wzero got lat=%0d ce=%0d want lat=1 ce=0",
               lat, ce_cnt - c);
    end
  endtask

  task automatic test_random;
    int lat, p, wa;
    logic w;
    logic [3:0] b;
    logic [31:0] d, rd, other;
    logic [19:0] a;
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(0, 1);
      w = 1'($urandom);
      wa = $urandom_range(0, 31);
      b = 4'($urandom);
      d = $urandom;
      a = 20'(wa * 4 + $urandom_range(0, 3));
      a[19] = 1'($urandom);
      other = rdata[1-p];
      do_access(p, w, a, d, b, lat, rd);
      total++;
      if (lat != exp_lat(w, b)) begin
        bad++;
        $display("FAIL rnd_lat i=%0d got=%0d want=%0d", i, lat,
                 exp_lat(w, b));
      end
      if (w) ref_write(wa, d, b);
      else begin
        total++;
        if (rd !== ref_mem[wa]) begin
          bad++;
          $display("FAIL rnd_data i=%0d got=%h want=%h", i, rd,
                   ref_mem[wa]);
        end
      end
      total++;
      if (rdata[1-p] !== other) begin
        bad++;
        $display("FAIL rnd_hold i=%0d got=%h want=%h", i,
                 rdata[1-p], other);
      end
    end
  endtask

  task automatic test_rst_mid;
    int c0;
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 20'h00030;
    wdata[0] = $urandom; be[0] = 4'hF;
    @(negedge clk);
    total++;
    if (we_n !== 1'b0) begin
      bad++; $display("FAIL rst_mid_pre we_n got=%b want=0", we_n);
    end
    rst = 1'b1;
    c0 = rdy_cnt0;
    @(negedge clk);
    total++;
    if ({we_n, ce_n, dq_oe, rdy[0]} !== 4'b1100) begin
      bad++;
      $display("FAIL rst_mid we/ce/oe/rdy got=%b want=1100",
               {we_n, ce_n, dq_oe, rdy[0]});
    end
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (rdy_cnt0 != c0) begin
      bad++;
      $display("FAIL rst_mid_ready got=%0d pulses want=0", rdy_cnt0 - c0);
    end
  endtask

  task automatic port_seq(int p, int n);
    logic got;
    for (int i = 0; i < n; i++) begin
      req[p] = 1'b1; wr[p] = 1'b0;
      addr[p] = 20'((p * 8 + i) * 4); be[p] = 4'h0;
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (rdy[p]) begin got = 1'b1; break; end
      end
      total++;
      if (!got || rdata[p] !== ref_mem[p * 8 + i]) begin
        bad++;
        $display("FAIL rr_data p=%0d i=%0d got=%h ready=%b want=%h",
                 p, i, rdata[p], got, ref_mem[p * 8 + i]);
      end
    end
    req[p] = 1'b0;
  endtask

  task automatic test_contention;
    int g0, b0;
    g0 = grant_q.size();
    b0 = both_cnt;
    fork
      port_seq(0, 4);
      port_seq(1, 4);
    join
    @(negedge clk);
    total++;
    if (grant_q.size() - g0 != 8) begin
      bad++;
      $display("FAIL rr_count got=%0d want=8", grant_q.size() - g0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (grant_q[g0 + i] != i % 2) begin
          bad++;
          $display("FAIL rr_order slot=%0d got=m%0d want=m%0d", i,
                   grant_q[g0 + i], i % 2);
        end
      end
    end
    total++;
    if (both_cnt != b0) begin
      bad++;
      $display("FAIL rr_both got=%0d want=0", both_cnt - b0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_write_full();
    test_write_half();
    test_random();
    test_rst_mid();
    test_contention();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
